// File: rtl/addsub_accumulate_controller.sv
// Dot-product row accumulator: folds LENGTH signed add/sub operands into a
// running sum through one shared adder/subtractor, then presents the sum and
// a sticky overflow flag on a valid/ready output.

`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

// Combinational two's-complement adder/subtractor with signed overflow flag.
module signed_adder_subtractor #(
    parameter int BIT_WIDTH = `BIT_WIDTH
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 operation,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 overflow
);
    // Subtract flips the sign test on b; overflow when result sign departs
    // from a while the effective operand signs agree.
    always_comb begin
        result   = operation ? (a - b) : (a + b);
        overflow = operation
                 ? ((a[BIT_WIDTH-1] != b[BIT_WIDTH-1]) && (result[BIT_WIDTH-1] != a[BIT_WIDTH-1]))
                 : ((a[BIT_WIDTH-1] == b[BIT_WIDTH-1]) && (result[BIT_WIDTH-1] != a[BIT_WIDTH-1]));
    end
endmodule

module addsub_accumulate_controller #(
    parameter int BIT_WIDTH   = `BIT_WIDTH,
    parameter int LENGTH      = 4,
    parameter int COUNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_result,
    output logic                 out_overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(LENGTH - 1);

    state_t                 state, state_nxt;
    logic [BIT_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] count;
    logic                   ovf;
    logic [BIT_WIDTH-1:0]   sum;
    logic                   sum_ovf;
    logic                   accept;

    signed_adder_subtractor #(.BIT_WIDTH(BIT_WIDTH)) u_addsub (
        .a         (acc),
        .b         (in_data),
        .operation (in_op),
        .result    (sum),
        .overflow  (sum_ovf)
    );

    assign accept = in_valid && in_ready;

    // Next state and handshake outputs; all outputs derive from state only.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && count == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; acc survives into IDLE until next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if (accept) begin
                acc   <= sum;
                ovf   <= ovf | sum_ovf;
                count <= (count == LAST) ? '0 : count + 1'b1;
            end
        end
    end

    assign out_result   = acc;
    assign out_overflow = ovf;
endmodule

// File: tb/tb_addsub_accumulate_controller.sv
// Randomized and directed bench for the accumulate controller; expected sums
// come from integer arithmetic with explicit range checks.
module tb_addsub_accumulate_controller;
    localparam int W = 16;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_overflow;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] op_d [L];
    bit           op_o [L];

    addsub_accumulate_controller #(.BIT_WIDTH(W), .LENGTH(L), .COUNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum, range-checked after every step, then wrapped.
    task automatic model(output logic [W-1:0] r, output bit v);
        int acc;
        int t;
        logic [W-1:0] w;
        acc = 0;
        v   = 1'b0;
        for (int i = 0; i < L; i++) begin
            t = op_o[i] ? acc - int'($signed(op_d[i])) : acc + int'($signed(op_d[i]));
            if (t > 32767 || t < -32768) v = 1'b1;
            w   = t[W-1:0];
            acc = int'($signed(w));
        end
        r = acc[W-1:0];
    endtask

    task automatic set_ops(input logic [W-1:0] d0, d1, d2, d3, input bit o0, o1, o2, o3);
        op_d[0] = d0; op_d[1] = d1; op_d[2] = d2; op_d[3] = d3;
        op_o[0] = o0; op_o[1] = o1; op_o[2] = o2; op_o[3] = o3;
    endtask

    // One full run; start_at >= 0 raises start alongside that operand.
    task automatic do_run(input int gaps, input int stall, input bit start_in_done, input int start_at);
        logic [W-1:0] er;
        bit           ev;
        model(er, ev);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_run", busy, 1);
        for (int i = 0; i < L; i++) begin
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                tick();
                chk("bubble_novalid", out_valid, 0);
            end
            in_valid = 1'b1;
            in_data  = op_d[i];
            in_op    = op_o[i];
            start    = (i == start_at);
            chk("in_ready_run", in_ready, 1);
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            if (i < L - 1) chk("no_early_valid", out_valid, 0);
        end
        chk("out_valid", out_valid, 1);
        chk("result", out_result, er);
        chk("overflow", out_overflow, ev);
        chk("in_ready_done", in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            start     = start_in_done;
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_result", out_result, er);
            chk("stall_ovf", out_overflow, ev);
        end
        out_ready = 1'b1;
        start     = start_in_done;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("acc_kept", out_result, er);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_ovf", out_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        set_ops(16'h1234, 16'h5678, 16'h0100, 16'h0010, 0, 0, 1, 0);
        do_run(0, 0, 0, -1);
        chk("t1_const", out_result, 16'h67BC);
        set_ops(16'hF000, 16'hE000, 16'h1000, 16'h0000, 0, 0, 1, 0);
        do_run(0, 0, 0, -1);
        chk("t2_const", out_result, 16'hC000);
        set_ops(16'h7FFF, 16'h0001, 16'h0001, 16'h0000, 0, 0, 1, 0);
        do_run(0, 1, 0, -1);
        chk("t3_const", out_result, 16'h7FFF);
        // backpressure, bubbles, start ignored in DONE
        set_ops(16'h1234, 16'h5678, 16'h0100, 16'h0010, 0, 0, 1, 0);
        do_run(3, 5, 1, -1);

        // async reset after two accepts
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 16'h4000; in_op = 1'b0; tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_result", out_result, 0);
        chk("arst_ovf", out_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        set_ops(16'h1234, 16'h5678, 16'h0100, 16'h0010, 0, 0, 1, 0);
        do_run(0, 0, 0, -1);

        // operand offered in IDLE is ignored
        in_valid = 1'b1; in_data = 16'h0005; in_op = 1'b0;
        chk("idle_noready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("idle_acc_hold", out_result, 16'h67BC);
        chk("idle_stay", busy, 0);
        // start during RUN does not reset the count or sum
        set_ops(16'h0003, 16'h0004, 16'hFFFF, 16'h0002, 0, 0, 1, 1);
        do_run(0, 0, 0, 1);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < L; i++) begin
                op_d[i] = W'($urandom);
                op_o[i] = bit'($urandom_range(0, 1));
            end
            do_run(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/addsub_accumulate_controller.md
Name: addsub_accumulate_controller

Overview:
Sequencing controller that runs the shared signed_adder_subtractor as a running accumulator for one matrix-multiply dot-product row. It accepts a stream of LENGTH signed operands, each tagged add or subtract, and folds each into an internal accumulator through one structural signed_adder_subtractor instance. When the stream is complete it presents the final sum and a sticky overflow flag on a valid/ready output handshake.

Parameters:
BIT_WIDTH, `BIT_WIDTH (16), operand/accumulator width, two's complement
LENGTH, 4, operands per accumulation run (>=2)
COUNT_WIDTH, 2, element counter width; must satisfy 2**COUNT_WIDTH >= LENGTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; honoured only in IDLE
busy  output  1  high whenever state != IDLE
in_valid  input  1  operand present
in_ready  output  1  controller accepts operand this cycle
in_data  input  BIT_WIDTH  signed operand
in_op  input  1  0 = acc + in_data, 1 = acc - in_data
out_valid  output  1  final result available
out_ready  input  1  consumer takes result
out_result  output  BIT_WIDTH  accumulator register, signed
out_overflow  output  1  sticky OR of adder overflow over the run

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- While rst is high:
  - state = IDLE.
  - The accumulator, element count and overflow flag are 0.
  - Outputs: busy 0, in_ready 0, out_valid 0, out_result 0, out_overflow 0.
- Datapath: one signed_adder_subtractor instance with a = acc, b = in_data, operation = in_op. It is purely combinational. All state is registered in this block.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - On start = 1: at that edge, acc <= 0, count <= 0, ovf <= 0, state <= RUN.
  - in_valid is ignored in IDLE.
- RUN:
  - in_ready = 1 (combinational from state only).
  - Each cycle with in_valid & in_ready: acc <= adder result, ovf <= ovf | adder overflow, count <= count + 1.
  - On the accept where count == LENGTH-1: state <= DONE and count wraps to 0.
  - Cycles with in_valid = 0 hold all state (bubbles allowed).
- DONE:
  - in_ready = 0, out_valid = 1.
  - out_result and out_overflow hold stable until out_valid & out_ready; at that edge state <= IDLE.
  - acc keeps its value in IDLE until the next start.
- Latency: out_valid rises on the cycle after the final operand is accepted. Minimum run is 1 (start) + LENGTH (accepts) + 1 (drain) cycles.
- start is ignored in RUN and DONE. In particular, start together with out_ready in DONE does not restart; a new start is needed in IDLE.
- Arithmetic: two's-complement wrap-around, no saturation.
  - Overflow is that of each individual add/sub, as reported by the adder instance.
  - Once set, out_overflow stays 1 for the rest of the run, even if later operations bring the value back into range.
- out_result = acc at all times. It is only meaningful while out_valid = 1.
- rst asserted mid-run (RUN or DONE) aborts immediately. All outputs drop to reset values without waiting for clk, and no partial result is emitted.
- Target implementation size: 150-250 lines, single always block for FSM/registers plus the adder instance.

Test Plan:
1. Mixed signs, no overflow (BIT_WIDTH=16, LENGTH=4): start, then 0x1234 add, 0x5678 add, 0x0100 sub, 0x0010 add -> out_valid one cycle after 4th accept, out_result 0x67BC, out_overflow 0.
2. Negatives: 0xF000 add, 0xE000 add, 0x1000 sub, 0x0000 add -> out_result 0xC000 (-16384), out_overflow 0.
3. Overflow sticky/wrap: 0x7FFF add, 0x0001 add (acc 0x8000, ovf), 0x0001 sub (acc 0x7FFF), 0x0000 add -> out_result 0x7FFF, out_overflow 1.
4. Backpressure and bubbles:
   - Insert 3 in_valid-low cycles between operands, then hold out_ready low 5 cycles.
   - Required: accepts only when in_valid high; out_valid, out_result and out_overflow stable during stall; in_ready 0 in DONE.
   - start pulsed in DONE is ignored; out_ready high -> IDLE next edge.
5. Reset mid-run: assert rst asynchronously after 2 accepts -> busy, in_ready, out_valid, out_result, out_overflow all 0 before the next clk edge. A following clean run of test 1 gives 0x67BC.
6. Idle/protocol guard: in_valid = 1 with data 0x0005 in IDLE -> in_ready 0, acc unchanged. start during RUN after 1 accept -> count not reset; run completes after 3 more accepts with the correct sum.
